// File: rtl/free_list.sv
// free_list
// Physical-register free list for the 3-wide rename/dispatch stage. It is a
// ring buffer of free PR numbers. Allocation pops from head and retirement
// pushes Told at tail. A squash makes every in-flight Tnew free again in one
// cycle by pulling head back to the post-retire tail. Way 2 is always the
// oldest instruction of a group.
//
// Ports
//   clock          system clock, all state updates on posedge
//   reset          synchronous, active-high
//   dis_new_pr_en  per-way allocate request (bit 2 = oldest)
//   retire_en      per-way retire valid from ROB commit (bit 2 = oldest)
//   retire_told    Told of each retiring way
//   squash         precise-state recovery request
//   free_pr_valid  thermometer from way 2 of available PRs
//   free_pr        PR offered to each way, combinational on dis_new_pr_en
//   fl_count       current number of free entries
module free_list #(
  parameter int PR_NUM = 64,
  parameter int AR_NUM = 32,
  parameter int PR_W   = $clog2(PR_NUM)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [2:0]                             dis_new_pr_en,
  input  logic [2:0]                             retire_en,
  input  logic [2:0][PR_W-1:0]                   retire_told,
  input  logic                                   squash,
  output logic [2:0]                             free_pr_valid,
  output logic [2:0][PR_W-1:0]                   free_pr,
  output logic [$clog2(PR_NUM-AR_NUM+1)-1:0]     fl_count
);

  localparam int FL_DEPTH = PR_NUM - AR_NUM;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);
  localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(FL_DEPTH);
  localparam logic [CNT_W-1:0] FULL_P = CNT_W'(FL_DEPTH);

  logic [PR_W-1:0]  slots_q [FL_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]             pops;
  logic [1:0]             pushes;
  logic [2:0]             wrEn;
  logic [2:0][PTR_W-1:0]  wrAddr;

  // Pointer advance with wrap, written so a non power-of-two depth still
  // wraps without a gap.
  function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] p,
                                               input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_W-1:0];
  endfunction

  // Allocation: enabled ways take consecutive slots from head, oldest way
  // first. Only as many ways as there are free entries actually pop, so an
  // over-request can never underflow head or count.
  always_comb begin
    logic [1:0] allocIdx;
    allocIdx = '0;
    pops     = '0;
    free_pr  = '0;
    for (int w = 2; w >= 0; w--) begin
      if (dis_new_pr_en[w]) begin
        free_pr[w] = slots_q[ptrAdd(head_q, allocIdx)];
        if (CNT_W'(allocIdx) < count_q) pops = pops + 2'd1;
        allocIdx = allocIdx + 2'd1;
      end else begin
        free_pr[w] = slots_q[head_q];
      end
    end
  end

  // Retirement: enabled ways write consecutive slots from tail, oldest first.
  always_comb begin
    logic [1:0] pushIdx;
    pushIdx = '0;
    wrEn    = '0;
    wrAddr  = '0;
    for (int w = 2; w >= 0; w--) begin
      if (retire_en[w]) begin
        wrEn[w]   = 1'b1;
        wrAddr[w] = ptrAdd(tail_q, pushIdx);
        pushIdx   = pushIdx + 2'd1;
      end
    end
    pushes = pushIdx;
  end

  // Next state. A squash keeps the same-cycle retires, then restarts
  // allocation at the new tail: the slots between tail and the old head
  // still hold the popped Tnews, so they become free without a walk.
  always_comb begin
    tail_d = ptrAdd(tail_q, pushes);
    if (squash) begin
      head_d  = tail_d;
      count_d = FULL_P;
    end else begin
      head_d  = ptrAdd(head_q, pops);
      count_d = count_q - CNT_W'(pops) + CNT_W'(pushes);
    end
  end

  // State registers; reset restores the identity mapping of PRs
  // AR_NUM..PR_NUM-1 into the ring and overrides any same-cycle activity.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) slots_q[i] <= PR_W'(AR_NUM + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FULL_P;
    end else begin
      for (int w = 0; w < 3; w++) begin
        if (wrEn[w]) slots_q[wrAddr[w]] <= retire_told[w];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Thermometer of available PRs starting from the oldest way.
  always_comb begin
    if (count_q >= CNT_W'(3))      free_pr_valid = 3'b111;
    else if (count_q == CNT_W'(2)) free_pr_valid = 3'b110;
    else if (count_q == CNT_W'(1)) free_pr_valid = 3'b100;
    else                           free_pr_valid = 3'b000;
  end

  assign fl_count = count_q;

endmodule
